// File: rtl/tap_stream_reader.sv
// Read-side walker for the circular sample buffer: on each committed sample it
// streams DEPTH taps, newest first, over a valid/ready handshake and accumulates
// the burst's sum of squares for use as an NLMS normalisation energy.
module tap_stream_reader #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned DW    = 16,
  parameter int unsigned EW    = 38
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  ready_in,
  input  logic [AW-1:0]         offset_in,
  input  logic [DEPTH*DW-1:0]   sample_in,
  input  logic                  tap_ready_in,
  output logic                  tap_valid_out,
  output logic                  tap_last_out,
  output logic [AW-1:0]         tap_idx_out,
  output logic [DW-1:0]         tap_sample_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [EW-1:0]         energy_out,
  output logic                  overrun_out
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStream = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);
  localparam logic [AW-1:0] OneIdx  = AW'(1);

  logic [1:0]      state_q;
  logic [AW-1:0]   off_q;
  logic [AW-1:0]   tap_idx_q;
  logic [DW-1:0]   tap_sample_q;
  logic            tap_valid_q;
  logic [EW-1:0]   acc_q;
  logic [EW-1:0]   energy_q;
  logic            overrun_q;

  logic                   xfer;
  logic                   is_last;
  logic [AW-1:0]          rd_idx;
  logic [DW-1:0]          rd_sample;
  logic signed [2*DW-1:0] samp_ext;
  logic [2*DW-1:0]        sq;
  logic [EW-1:0]          acc_sum;

  // Handshake decode, buffer read mux and square-accumulate datapath.
  always_comb begin
    xfer     = tap_valid_q & tap_ready_in;
    is_last  = (tap_idx_q == LastIdx);
    // A start reads the new newest entry; otherwise prefetch tap k+1 (mod DEPTH).
    rd_idx    = ready_in ? offset_in : (off_q - tap_idx_q - OneIdx);
    rd_sample = sample_in[rd_idx * DW +: DW];
    samp_ext = {{DW{tap_sample_q[DW-1]}}, tap_sample_q};
    // Square of a signed value is non-negative and fits in 2*DW bits.
    sq       = samp_ext * samp_ext;
    acc_sum  = acc_q + EW'(sq);
  end

  // Burst FSM and tap/accumulator registers; a start (ready_in) always wins
  // over streaming and restarts from the new offset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= StIdle;
      off_q        <= '0;
      tap_idx_q    <= '0;
      tap_sample_q <= '0;
      tap_valid_q  <= 1'b0;
      acc_q        <= '0;
      energy_q     <= '0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (ready_in) begin
        // Start while streaming aborts the burst, even on its final transfer.
        overrun_q    <= (state_q == StStream);
        state_q      <= StStream;
        off_q        <= offset_in;
        tap_idx_q    <= '0;
        tap_sample_q <= rd_sample;
        tap_valid_q  <= 1'b1;
        acc_q        <= '0;
      end else begin
        case (state_q)
          StStream: begin
            if (xfer) begin
              if (is_last) begin
                energy_q    <= acc_sum;
                acc_q       <= '0;
                tap_valid_q <= 1'b0;
                state_q     <= StDone;
              end else begin
                acc_q        <= acc_sum;
                tap_idx_q    <= tap_idx_q + OneIdx;
                tap_sample_q <= rd_sample;
              end
            end
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Outputs are decoded straight from registered state.
  always_comb begin
    tap_valid_out  = tap_valid_q;
    tap_last_out   = tap_valid_q & is_last;
    tap_idx_out    = tap_idx_q;
    tap_sample_out = tap_sample_q;
    busy_out       = (state_q == StStream);
    done_out       = (state_q == StDone);
    energy_out     = energy_q;
    overrun_out    = overrun_q;
  end

endmodule
